// File: rtl/r4_pkg.sv
// Shared constants and state encoding for the radix-4 butterfly sequencer.
// Default width and per-step control codes {c1,c2,c3}.
package r4_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] DEF_CODE0 = 3'b000;
  localparam logic [2:0] DEF_CODE1 = 3'b001;
  localparam logic [2:0] DEF_CODE2 = 3'b010;
  localparam logic [2:0] DEF_CODE3 = 3'b011;

endpackage

// File: rtl/r4_bfly_dp.sv
// Combinational radix-4 butterfly datapath, modulo 2^W arithmetic.
// c1 swaps re/im of x0 and x2; c2/c3 pick add/sub; m4=c2^c3.
module r4_bfly_dp #(
  parameter int W = 4
) (
  input  logic [W-1:0] xr0,
  input  logic [W-1:0] xi0,
  input  logic [W-1:0] xr1,
  input  logic [W-1:0] xi1,
  input  logic [W-1:0] xr2,
  input  logic [W-1:0] xi2,
  input  logic [W-1:0] xr3,
  input  logic [W-1:0] xi3,
  input  logic         c1,
  input  logic         c2,
  input  logic         c3,
  output logic [W-1:0] re,
  output logic [W-1:0] im
);

  logic         m4;
  logic [W-1:0] a0, b0, a2, b2;
  logic [W-1:0] s0, s1, s2, s3;

  assign m4 = c2 ^ c3;

  assign a0 = c1 ? xi0 : xr0;
  assign b0 = c1 ? xr0 : xi0;
  assign a2 = c1 ? xi2 : xr2;
  assign b2 = c1 ? xr2 : xi2;

  assign s0 = c2 ? a0 - xr1 : a0 + xr1;
  assign s1 = c2 ? a2 - xr3 : a2 + xr3;
  assign s2 = c3 ? b0 - xi1 : b0 + xi1;
  assign s3 = c3 ? b2 - xi3 : b2 + xi3;

  assign re = m4 ? s0 - s1 : s0 + s1;
  assign im = m4 ? s3 - s2 : s3 + s2;

endmodule

// File: rtl/r4_bfly_seq.sv
// Stream sequencer: loads 4 complex samples, then emits 4 butterfly
// results (one per control code) over a valid/ready output.
module r4_bfly_seq
  import r4_pkg::*;
#(
  parameter int         WIDTH = DEF_WIDTH,
  parameter logic [2:0] CODE0 = DEF_CODE0,
  parameter logic [2:0] CODE1 = DEF_CODE1,
  parameter logic [2:0] CODE2 = DEF_CODE2,
  parameter logic [2:0] CODE3 = DEF_CODE3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [1:0]       out_idx,
  output logic             out_last
);

  state_t           state, state_d;
  logic [1:0]       cnt, cnt_d;
  logic [1:0]       step, step_d;
  logic             valid_d;
  logic             wr_slot;
  logic             load_res;
  logic [2:0]       code;
  logic [WIDTH-1:0] xr [4];
  logic [WIDTH-1:0] xi [4];
  logic [WIDTH-1:0] xr3, xi3;
  logic [WIDTH-1:0] dp_re, dp_im;

  assign in_ready = (state == LOAD);
  assign out_idx  = step;
  assign out_last = out_valid && (step == 2'd3);

  // Slot 3 is bypassed from the input so step 0 registers on the 4th accept.
  assign xr3 = (state == LOAD) ? in_re : xr[3];
  assign xi3 = (state == LOAD) ? in_im : xi[3];

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    step_d   = step;
    valid_d  = out_valid;
    wr_slot  = 1'b0;
    load_res = 1'b0;
    case (state)
      LOAD: begin
        if (in_valid) begin
          wr_slot = 1'b1;
          cnt_d   = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_d  = RUN;
            step_d   = 2'd0;
            valid_d  = 1'b1;
            load_res = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_valid && out_ready) begin
          if (step == 2'd3) begin
            state_d = LOAD;
            step_d  = 2'd0;
            valid_d = 1'b0;
          end else begin
            step_d   = step + 2'd1;
            load_res = 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    code = CODE0;
    case (step_d)
      2'd0: code = CODE0;
      2'd1: code = CODE1;
      2'd2: code = CODE2;
      2'd3: code = CODE3;
      default: code = CODE0;
    endcase
  end

  r4_bfly_dp #(.W(WIDTH)) u_dp (
    .xr0 (xr[0]),
    .xi0 (xi[0]),
    .xr1 (xr[1]),
    .xi1 (xi[1]),
    .xr2 (xr[2]),
    .xi2 (xi[2]),
    .xr3 (xr3),
    .xi3 (xi3),
    .c1  (code[2]),
    .c2  (code[1]),
    .c3  (code[0]),
    .re  (dp_re),
    .im  (dp_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= 2'd0;
      step      <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      step      <= step_d;
      out_valid <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        xr[i] <= '0;
        xi[i] <= '0;
      end
      out_re <= '0;
      out_im <= '0;
    end else begin
      if (wr_slot) begin
        xr[cnt] <= in_re;
        xi[cnt] <= in_im;
      end
      if (load_res) begin
        out_re <= dp_re;
        out_im <= dp_im;
      end
    end
  end

endmodule

// File: tb/tb_r4_bfly_seq.sv
// Scoreboard bench for r4_bfly_seq: directed frames with hand-computed
// results, backpressure, input gaps, held in_valid and mid-frame resets.
module tb_r4_bfly_seq;

  typedef struct {
    logic [3:0] re;
    logic [3:0] im;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  typedef logic [3:0] nib4_t [4];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_re = '0;
  logic [3:0] in_im = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_re;
  logic [3:0] out_im;
  logic [1:0] out_idx;
  logic       out_last;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  r4_bfly_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // frame 1: (1,2),(3,4),(5,6),(7,8)
  localparam nib4_t F1R  = '{4'd1, 4'd3, 4'd5, 4'd7};
  localparam nib4_t F1I  = '{4'd2, 4'd4, 4'd6, 4'd8};
  localparam nib4_t F1ER = '{4'd0, 4'd8, 4'd0, 4'd12};
  localparam nib4_t F1EI = '{4'd4, 4'd0, 4'd8, 4'd12};
  // frame 2: all (15,15), exercises wrap
  localparam nib4_t F2R  = '{4'd15, 4'd15, 4'd15, 4'd15};
  localparam nib4_t F2I  = '{4'd15, 4'd15, 4'd15, 4'd15};
  localparam nib4_t F2ER = '{4'd12, 4'd0, 4'd0, 4'd0};
  localparam nib4_t F2EI = '{4'd12, 4'd0, 4'd0, 4'd0};
  // frame 3: (2,9),(4,1),(11,3),(0,6)
  localparam nib4_t F3R  = '{4'd2, 4'd4, 4'd11, 4'd0};
  localparam nib4_t F3I  = '{4'd9, 4'd1, 4'd3, 4'd6};
  localparam nib4_t F3ER = '{4'd1, 4'd11, 4'd3, 4'd9};
  localparam nib4_t F3EI = '{4'd3, 4'd5, 4'd15, 4'd5};

  task automatic check1(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check1({tag, " in_ready"}, int'(in_ready), 1);
    check1({tag, " out_valid"}, int'(out_valid), 0);
    check1({tag, " out_re"}, int'(out_re), 0);
    check1({tag, " out_im"}, int'(out_im), 0);
    check1({tag, " out_idx"}, int'(out_idx), 0);
    check1({tag, " out_last"}, int'(out_last), 0);
  endtask

  task automatic send_one(input logic [3:0] re, input logic [3:0] im);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_err++;
      $display("FAIL in_ready timeout: got 0 want 1");
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input nib4_t r, input nib4_t i,
                            input nib4_t er, input nib4_t ei,
                            input bit gap, input bit hold);
    for (int s = 0; s < 4; s++)
      q.push_back('{re: er[s], im: ei[s], idx: 2'(s), last: (s == 3)});
    for (int s = 0; s < 4; s++) begin
      if (gap && s > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_re    = 4'hA;
        in_im    = 4'h5;
      end
      send_one(r[s], i[s]);
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    check1("first result latency", int'(out_valid), 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain timeout: got %0d pending want 0", q.size());
      q.delete();
    end
    #2;
    check1("idle out_valid", int'(out_valid), 0);
    check1("idle in_ready", int'(in_ready), 1);
  endtask

  task automatic wait_idx(input logic [1:0] idx);
    int k;
    k = 0;
    while (!(out_valid && out_idx == idx) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!(out_valid && out_idx == idx)) begin
      n_err++;
      $display("FAIL wait idx%0d timeout: got idx %0d want %0d",
               idx, out_idx, idx);
    end
  endtask

  // Monitor: compares the presented result against the queue head every
  // cycle, so held values during a stall are also checked.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected result: got re=%0d im=%0d idx=%0d want none",
                   out_re, out_im, out_idx);
        end else begin
          e = q[0];
          n_vec++;
          if (out_re !== e.re || out_im !== e.im ||
              out_idx !== e.idx || out_last !== e.last || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL result idx%0d: got re=%0d im=%0d idx=%0d last=%0d rdy=%0d want re=%0d im=%0d idx=%0d last=%0d rdy=0",
                     e.idx, out_re, out_im, out_idx, out_last, in_ready,
                     e.re, e.im, e.idx, e.last);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;

    send_frame(F1R, F1I, F1ER, F1EI, 1'b0, 1'b0);
    drain();

    send_frame(F1R, F1I, F1ER, F1EI, 1'b0, 1'b0);
    wait_idx(2'd1);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    drain();

    send_frame(F3R, F3I, F3ER, F3EI, 1'b1, 1'b0);
    drain();

    send_frame(F2R, F2I, F2ER, F2EI, 1'b0, 1'b1);
    in_re = F3R[0];
    in_im = F3I[0];
    send_frame(F3R, F3I, F3ER, F3EI, 1'b0, 1'b0);
    drain();

    send_one(4'd9, 4'd9);
    send_one(4'd6, 4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check_reset_outs("reset mid-load");
    @(negedge clk);
    rst = 1'b0;
    send_frame(F1R, F1I, F1ER, F1EI, 1'b0, 1'b0);
    drain();

    send_frame(F3R, F3I, F3ER, F3EI, 1'b0, 1'b0);
    wait_idx(2'd2);
    rst = 1'b1;
    q.delete();
    #2;
    check_reset_outs("reset mid-run");
    @(negedge clk);
    rst = 1'b0;
    #2;
    check1("post-reset out_valid", int'(out_valid), 0);
    send_frame(F2R, F2I, F2ER, F2EI, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
